// File: rtl/fwd_bypass_unit.sv
// EX-stage operand forwarding: tracks the last NStages producers and picks the
// youngest matching result per source operand; also flags load-use hazards.
module fwd_bypass_unit #(
  parameter int NBits   = 32,
  parameter int NStages = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Hold,
  input  logic                     Ex_Valid,
  input  logic                     Ex_RegWrite,
  input  logic                     Ex_MemRead,
  input  logic [4:0]               Ex_Rd,
  input  logic [4:0]               Ex_Rs,
  input  logic [4:0]               Ex_Rt,
  input  logic [4:0]               Id_Rs,
  input  logic [4:0]               Id_Rt,
  input  logic [NBits-1:0]         Rs_RegFile_Data,
  input  logic [NBits-1:0]         Rt_RegFile_Data,
  input  logic [NStages*NBits-1:0] Stage_Result,
  output logic [NBits-1:0]         Rs_Operand,
  output logic [NBits-1:0]         Rt_Operand,
  output logic [2:0]               Rs_Sel,
  output logic [2:0]               Rt_Sel,
  output logic                     Load_Use_Stall,
  output logic                     Hazard_Error,
  output logic [15:0]              Fwd_Count
);

  logic [NStages-1:0] ent_v;
  logic [NStages-1:0] ent_rw;
  logic [4:0]         ent_rd [NStages];
  // Load data only matters while the load sits in stage 0, so older MR bits are not kept.
  logic               ent0_mr;
  logic               load_hit;
  logic               any_fwd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_v   <= '0;
      ent_rw  <= '0;
      ent0_mr <= 1'b0;
      for (int k = 0; k < NStages; k++) ent_rd[k] <= '0;
    end else if (!Hold) begin
      ent_v[0]  <= Ex_Valid;
      ent_rw[0] <= Ex_RegWrite;
      ent0_mr   <= Ex_MemRead;
      ent_rd[0] <= Ex_Rd;
      for (int k = 1; k < NStages; k++) begin
        ent_v[k]  <= ent_v[k-1];
        ent_rw[k] <= ent_rw[k-1];
        ent_rd[k] <= ent_rd[k-1];
      end
    end
  end

  // Walk oldest to youngest so the youngest producer overwrites the selection.
  always_comb begin
    Rs_Sel = '0;
    Rt_Sel = '0;
    for (int k = NStages - 1; k >= 0; k--) begin
      if (ent_v[k] && ent_rw[k] && (ent_rd[k] != 5'd0)) begin
        if (ent_rd[k] == Ex_Rs) Rs_Sel = 3'(k + 1);
        if (ent_rd[k] == Ex_Rt) Rt_Sel = 3'(k + 1);
      end
    end
  end

  always_comb begin
    Rs_Operand = Rs_RegFile_Data;
    Rt_Operand = Rt_RegFile_Data;
    for (int k = 0; k < NStages; k++) begin
      if (Rs_Sel == 3'(k + 1)) Rs_Operand = Stage_Result[k*NBits +: NBits];
      if (Rt_Sel == 3'(k + 1)) Rt_Operand = Stage_Result[k*NBits +: NBits];
    end
  end

  assign load_hit = ent0_mr && ((Rs_Sel == 3'd1) || (Rt_Sel == 3'd1));
  assign any_fwd  = (Rs_Sel != 3'd0) || (Rt_Sel != 3'd0);

  assign Load_Use_Stall = reset && Ex_Valid && Ex_MemRead && (Ex_Rd != 5'd0) &&
                          ((Ex_Rd == Id_Rs) || (Ex_Rd == Id_Rt));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Hazard_Error <= 1'b0;
      Fwd_Count    <= '0;
    end else begin
      if (load_hit) Hazard_Error <= 1'b1;
      if (any_fwd && (Fwd_Count != 16'hFFFF)) Fwd_Count <= Fwd_Count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fwd_bypass_unit.sv
// Scoreboard bench for fwd_bypass_unit: a history-queue reference model predicts
// each cycle's outputs, a negedge monitor pops and compares them.
module tb_fwd_bypass_unit;
  localparam int NB  = 32;
  localparam int NST = 4;

  logic clk = 1'b1;
  logic reset = 1'b0, hold = 1'b0;
  logic ex_valid = 1'b0, ex_rw = 1'b0, ex_mr = 1'b0;
  logic [4:0] ex_rd = '0, ex_rs = '0, ex_rt = '0, id_rs = '0, id_rt = '0;
  logic [NB-1:0] rs_rf = '0, rt_rf = '0;
  logic [NST*NB-1:0] stage_res = '0;

  logic [NB-1:0] rs_op, rt_op;
  logic [2:0] rs_sel, rt_sel;
  logic lus, herr;
  logic [15:0] fcnt;

  always #5 clk = ~clk;

  fwd_bypass_unit #(.NBits(NB), .NStages(NST)) dut (
    .clk(clk), .reset(reset), .Hold(hold),
    .Ex_Valid(ex_valid), .Ex_RegWrite(ex_rw), .Ex_MemRead(ex_mr),
    .Ex_Rd(ex_rd), .Ex_Rs(ex_rs), .Ex_Rt(ex_rt), .Id_Rs(id_rs), .Id_Rt(id_rt),
    .Rs_RegFile_Data(rs_rf), .Rt_RegFile_Data(rt_rf), .Stage_Result(stage_res),
    .Rs_Operand(rs_op), .Rt_Operand(rt_op), .Rs_Sel(rs_sel), .Rt_Sel(rt_sel),
    .Load_Use_Stall(lus), .Hazard_Error(herr), .Fwd_Count(fcnt)
  );

  typedef struct packed { logic v; logic rw; logic mr; logic [4:0] rd; } ent_t;
  typedef struct { logic [2:0] rs_sel, rt_sel; logic [NB-1:0] rs_op, rt_op; logic lus, herr; logic [15:0] cnt; } exp_t;

  exp_t sb[$];
  ent_t hist[$];           // most recent EX instruction at index 0
  logic m_herr = 1'b0;
  int unsigned m_cnt = 0;
  logic [2:0] m_rs_sel, m_rt_sel;
  int n_vec = 0, n_err = 0;
  exp_t mon_e;

  function automatic logic [2:0] ref_sel(input logic [4:0] r);
    if (r == 5'd0) return 3'd0;
    for (int k = 0; k < hist.size(); k++)
      if (hist[k].v && hist[k].rw && hist[k].rd == r) return 3'(k + 1);
    return 3'd0;
  endfunction

  function automatic logic [NB-1:0] ref_data(input logic [2:0] sel, input logic [NB-1:0] rf);
    if (sel == 3'd0) return rf;
    return stage_res[(int'(sel) - 1)*NB +: NB];
  endfunction

  task automatic rand_data();
    rs_rf = $urandom;
    rt_rf = $urandom;
    for (int k = 0; k < NST; k++) stage_res[k*NB +: NB] = $urandom;
  endtask

  task automatic set_ex(input logic v, input logic rw, input logic mr, input logic [4:0] rd,
                        input logic [4:0] rs, input logic [4:0] rt);
    ex_valid = v; ex_rw = rw; ex_mr = mr; ex_rd = rd; ex_rs = rs; ex_rt = rt;
  endtask

  // Predict this cycle, then advance the model across the next rising edge.
  task automatic apply();
    exp_t e;
    ent_t n;
    if (!reset) begin
      hist.delete();
      m_herr = 1'b0;
      m_cnt  = 0;
    end
    m_rs_sel = ref_sel(ex_rs);
    m_rt_sel = ref_sel(ex_rt);
    e.rs_sel = m_rs_sel;
    e.rt_sel = m_rt_sel;
    e.rs_op  = ref_data(m_rs_sel, rs_rf);
    e.rt_op  = ref_data(m_rt_sel, rt_rf);
    e.lus    = reset && ex_valid && ex_mr && (ex_rd != 0) && (ex_rd == id_rs || ex_rd == id_rt);
    e.herr   = m_herr;
    e.cnt    = 16'(m_cnt);
    sb.push_back(e);
    @(posedge clk);
    if (reset) begin
      if (hist.size() > 0 && hist[0].mr && (m_rs_sel == 3'd1 || m_rt_sel == 3'd1)) m_herr = 1'b1;
      if ((m_rs_sel != 0 || m_rt_sel != 0) && m_cnt < 65535) m_cnt++;
      if (!hold) begin
        n = '{v: ex_valid, rw: ex_rw, mr: ex_mr, rd: ex_rd};
        hist.push_front(n);
        if (hist.size() > NST) void'(hist.pop_back());
      end
    end
    #1;
  endtask

  task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("rs_sel", NB'(rs_sel), NB'(mon_e.rs_sel));
        chk("rt_sel", NB'(rt_sel), NB'(mon_e.rt_sel));
        chk("rs_operand", rs_op, mon_e.rs_op);
        chk("rt_operand", rt_op, mon_e.rt_op);
        chk("load_use_stall", NB'(lus), NB'(mon_e.lus));
        chk("hazard_error", NB'(herr), NB'(mon_e.herr));
        chk("fwd_count", NB'(fcnt), NB'(mon_e.cnt));
      end
    end
  end

  initial begin
    #1;
    // reset held: writer and load-use candidates must all be ignored
    reset = 1'b0;
    set_ex(1, 1, 1, 5'd3, 5'd3, 5'd3);
    id_rs = 5'd3;
    repeat (3) begin rand_data(); apply(); end
    reset = 1'b1;
    id_rs = 0;

    // back-to-back ALU forward through every stage then out
    set_ex(1, 1, 0, 5'd5, 5'd0, 5'd0); rand_data(); apply();
    set_ex(0, 0, 0, 5'd0, 5'd5, 5'd0); rand_data();
    stage_res[0 +: NB] = 32'hDEADBEEF; apply();
    repeat (4) begin rand_data(); apply(); end

    // priority: two r7 writers, youngest wins; r0 writers never forward
    set_ex(1, 1, 0, 5'd7, 5'd0, 5'd0); rand_data(); apply(); apply();
    set_ex(0, 0, 0, 5'd0, 5'd7, 5'd7); rand_data();
    stage_res[0 +: NB] = 32'd11; stage_res[NB +: NB] = 32'd22; apply();
    set_ex(1, 1, 0, 5'd0, 5'd0, 5'd0); rand_data(); apply();
    set_ex(0, 0, 0, 5'd0, 5'd0, 5'd0); rand_data(); apply();

    // load-use stall, then forward from a load still in stage 0
    set_ex(1, 1, 1, 5'd0, 5'd0, 5'd0); id_rt = 5'd0; rand_data(); apply();
    set_ex(1, 1, 1, 5'd4, 5'd0, 5'd0); id_rt = 5'd4; rand_data(); apply();
    set_ex(0, 0, 0, 5'd0, 5'd0, 5'd4); id_rt = 5'd0; rand_data(); apply();
    set_ex(0, 0, 0, 5'd0, 5'd0, 5'd0);
    repeat (3) begin rand_data(); apply(); end

    // hold freezes the tracker but forwards are still counted
    set_ex(1, 1, 0, 5'd9, 5'd0, 5'd0); rand_data(); apply();
    set_ex(0, 0, 0, 5'd0, 5'd9, 5'd0); hold = 1'b1;
    repeat (3) begin rand_data(); apply(); end
    hold = 1'b0;
    repeat (2) begin rand_data(); apply(); end

    // randomized traffic with small register range and occasional reset
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(199) != 0);
      hold     = ($urandom_range(4) == 0);
      ex_valid = ($urandom_range(3) != 0);
      ex_rw    = ($urandom_range(3) != 0);
      ex_mr    = ($urandom_range(3) == 0);
      ex_rd    = 5'($urandom_range(7));
      ex_rs    = 5'($urandom_range(7));
      ex_rt    = 5'($urandom_range(7));
      id_rs    = 5'($urandom_range(7));
      id_rt    = 5'($urandom_range(7));
      rand_data();
      apply();
    end

    // mid-run reset then a producer aged through all four stages
    reset = 1'b0; hold = 1'b0; id_rs = 0; id_rt = 0;
    set_ex(1, 1, 0, 5'd12, 5'd12, 5'd0); rand_data(); apply();
    reset = 1'b1;
    set_ex(1, 1, 0, 5'd12, 5'd0, 5'd0); rand_data(); apply();
    set_ex(0, 0, 0, 5'd0, 5'd12, 5'd0);
    repeat (5) begin rand_data(); apply(); end

    // saturation: forward every cycle well past 16'hFFFF events
    set_ex(1, 1, 0, 5'd1, 5'd1, 5'd0);
    for (int i = 0; i < 70000; i++) begin rand_data(); apply(); end

    repeat (2) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fwd_bypass_unit.md
# fwd_bypass_unit

Parametrised operand-forwarding unit for the pipelined datapath's EX stage. It tracks the destination register of every in-flight producer in the last NStages pipeline stages and, per source operand, selects either register-file data or the youngest matching in-flight result. It also raises the load-use stall request and keeps a sticky hazard-error flag and a saturating forward-event counter. It replaces the fixed two-stage, single-operand forward mux with a depth-parametrised, two-operand tracker.

## Interface
- NBits, 32, datapath width
- NStages, 2, tracked producer stages after EX (stage 0 = EX/MEM, 1 = MEM/WB, ...); legal 1..4
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Hold  in  1  1 = freeze tracker (back-end stall)
- Ex_Valid, Ex_RegWrite, Ex_MemRead  in  1 each  attributes of the instruction currently in EX
- Ex_Rd  in  5  EX instruction destination register
- Ex_Rs, Ex_Rt  in  5 each  EX instruction source registers (consumer)
- Id_Rs, Id_Rt  in  5 each  ID instruction source registers (load-use check)
- Rs_RegFile_Data, Rt_RegFile_Data  in  NBits each  register-file read data
- Stage_Result  in  NStages*NBits  result of stage k in bits [k*NBits +: NBits]
- Rs_Operand, Rt_Operand  out  NBits each  forwarded operands
- Rs_Sel, Rt_Sel  out  3 each  0 = register file, k+1 = stage k
- Load_Use_Stall  out  1  stall request to ID/IF
- Hazard_Error  out  1  sticky: forward needed from a load still in stage 0
- Fwd_Count  out  16  saturating count of cycles with any forward

## Operation
- Tracker: NStages entries {V, RW, MR, Rd}. On each rising edge with Hold=0: entry 0 <= {Ex_Valid, Ex_RegWrite, Ex_MemRead, Ex_Rd}; entry k <= entry k-1. Hold=1: all entries keep value.
- Entry k "produces" r when V=1, RW=1, Rd=r, r≠0.
- Operand select (combinational, same for Rs and Rt): Sel = k+1 for the smallest k producing the source address; else 0. Register 0 always Sel=0. Operand = Rs/Rt_RegFile_Data when Sel=0, else Stage_Result slice k.
- Entry 0 with MR=1 producing the source: data not yet available. Sel still points to entry 0 (youngest wins, older entries not used); Hazard_Error set on next edge and held until reset.
- Load_Use_Stall = Ex_Valid & Ex_MemRead & (Ex_Rd≠0) & (Ex_Rd==Id_Rs | Ex_Rd==Id_Rt). Pure combinational; forced 0 while reset is low. The unit does not insert bubbles itself; the hazard controller must drive Ex_Valid=0 for the stalled slot.
- Fwd_Count: +1 on every edge where Rs_Sel≠0 or Rt_Sel≠0 (one increment per cycle, not per operand), counted also when Hold=1; saturates at 16'hFFFF.
- Rs and Rt matching the same entry: both forwarded from it, no conflict.

## Timing
- reset low (asynchronous): all entries V=0, Hazard_Error=0, Fwd_Count=0; hence Rs/Rt_Sel=0, operands = register-file data, Load_Use_Stall=0.
- Release of reset is synchronous to clk in the sense that the first capture happens on the first rising edge with reset high.
- Operand path: zero-latency combinational from Ex_Rs/Ex_Rt, Stage_Result and tracker state.
- Producer visibility: instruction in EX at cycle n is entry 0 in cycle n+1, entry k in cycle n+1+k (absent Hold), gone after NStages cycles.
- Hazard_Error and Fwd_Count update one edge after the qualifying condition.
- Reset asserted mid-operation: tracker cleared immediately; no stale forward after reset.

## Test plan
- Reset: hold reset low, drive Ex_Rs=3, garbage Stage_Result -> Rs_Sel=0, Rs_Operand=Rs_RegFile_Data, Fwd_Count=0, Load_Use_Stall=0.
- Back-to-back ALU: cycle n EX writes r5 (RW=1); cycle n+1 Ex_Rs=5, Stage_Result[0]=32'hDEADBEEF -> Rs_Sel=1, Rs_Operand=DEADBEEF; cycle n+2 same consumer -> Rs_Sel=2 with slice 1; cycle n+3 (NStages=2) -> Rs_Sel=0.
- Priority: entries 0 and 1 both write r7 with 11 and 22 -> Rs_Sel=1, operand 11; Rd=0 writers never forward (Sel=0).
- Load-use: Ex_MemRead=1, Ex_Rd=4, Id_Rt=4 -> Load_Use_Stall=1 same cycle; Id_Rt=0 with Ex_Rd=0 -> 0; let the load enter entry 0 and present Ex_Rt=4 -> Hazard_Error=1 next edge and stays 1.
- Hold: with r9 in entry 0, assert Hold for 3 cycles -> Rs_Sel stays 1 for Ex_Rs=9; Fwd_Count increments 3.
- Saturation/regression: NStages=4 build, forward every cycle for 70000 cycles -> Fwd_Count=16'hFFFF, Sel reaches 4 for a producer 4 stages old.
